activation_pipeline: RTL and testbench

ACTIVATION_PIPELINE -- requirements
Module: activation_pipeline

---
 rtl/activation_pipeline.sv | 144 ++++++++++++++
 tb/tb_activation_pipeline.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipeline.sv
// Three-stage per-lane activation unit (pass / ReLU / GELU approximation / leaky ReLU)
// with a valid/ready handshake, a global stall and a saturating count of clamped lanes.
module activation_pipeline #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4,
  parameter int SLOPE = 43
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [15:0]            sat_count
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_GELU  = 2'd2;
  localparam logic [1:0] MODE_LEAKY = 2'd3;

  localparam logic signed [W2-1:0] THR     = W2'(3 << FRAC);
  localparam logic signed [W2-1:0] HALF    = W2'(1 << (FRAC - 1));
  localparam logic signed [W2-1:0] SLOPE_W = W2'(SLOPE);
  localparam logic signed [W2-1:0] MAXV    = W2'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [W2-1:0] MINV    = ~MAXV;

  logic             adv;
  logic             s1_valid, s2_valid, s3_valid;
  logic [1:0]       s1_mode, s2_mode;
  logic [LANES-1:0] sat_lane;
  logic [4:0]       sat_n;
  logic [16:0]      sat_sum;

  // One enable for every stage: the whole pipe advances or freezes together.
  assign adv       = !s3_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_mode  <= MODE_PASS;
      s2_mode  <= MODE_PASS;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s3_valid <= s2_valid;
    end
  end

  always_comb begin
    sat_n = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sat_n = sat_n + {4'b0, sat_lane[i]};
    end
    sat_sum = {1'b0, sat_count} + {12'b0, sat_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (adv && s2_valid) begin
      sat_count <= sat_sum[16] ? '1 : sat_sum[15:0];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] x0, x1, x2, res, r3;
    logic signed [W2-1:0]    xe0, xe1, xe2, s_next, s2, y;
    logic                    lo1, hi1, lo2, hi2, sat;

    assign x0     = in_data[i*WIDTH +: WIDTH];
    assign xe0    = {{WIDTH{x0[WIDTH-1]}}, x0};
    assign xe1    = {{WIDTH{x1[WIDTH-1]}}, x1};
    assign xe2    = {{WIDTH{x2[WIDTH-1]}}, x2};
    assign s_next = HALF + ((SLOPE_W * xe1) >>> FRAC);
    assign y      = (xe2 * s2) >>> FRAC;

    always_comb begin
      res = x2;
      sat = 1'b0;
      case (s2_mode)
        MODE_PASS:  res = x2;
        MODE_RELU:  res = (x2 > 0) ? x2 : '0;
        MODE_LEAKY: res = x2[WIDTH-1] ? (x2 >>> 3) : x2;
        MODE_GELU: begin
          if (lo2) begin
            res = '0;
          end else if (!hi2) begin
            if (y > MAXV) begin
              res = MAXV[WIDTH-1:0];
              sat = 1'b1;
            end else if (y < MINV) begin
              res = MINV[WIDTH-1:0];
              sat = 1'b1;
            end else begin
              res = y[WIDTH-1:0];
            end
          end
        end
        default: res = x2;
      endcase
    end

    assign sat_lane[i] = sat;

    // Region flags are resolved in S1 so S3 only selects between branches.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x1  <= '0;
        lo1 <= 1'b0;
        hi1 <= 1'b0;
        x2  <= '0;
        lo2 <= 1'b0;
        hi2 <= 1'b0;
        s2  <= '0;
        r3  <= '0;
      end else if (adv) begin
        x1  <= x0;
        lo1 <= (xe0 < -THR);
        hi1 <= (xe0 > THR);
        x2  <= x1;
        lo2 <= lo1;
        hi2 <= hi1;
        s2  <= s_next;
        r3  <= res;
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = r3;
  end

endmodule

// File: tb/tb_activation_pipeline.sv
// Directed and randomized checks of activation_pipeline: latency, stall behaviour,
// per-mode arithmetic, saturation counting and mid-stream reset.
module tb_activation_pipeline;

  localparam int W  = 16;
  localparam int F  = 8;
  localparam int L  = 4;
  localparam int SL = 43;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_mode;
  logic [L*W-1:0] in_data, out_data;
  logic [15:0]   sat_count;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]    b_in_mode;
  logic [127:0]  b_in_data, b_out_data;
  logic [15:0]   b_sat_count;

  activation_pipeline #(.WIDTH(W), .FRAC(F), .LANES(L), .SLOPE(SL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_count(sat_count)
  );

  // Narrow instance with an exaggerated slope so the clamp path is reachable.
  activation_pipeline #(.WIDTH(8), .FRAC(4), .LANES(16), .SLOPE(40)) dut8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .sat_count(b_sat_count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]     mode;
    logic [L*W-1:0] data;
    logic [L*W-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic longint ref_lane(input int mode, input longint x, input int wd,
                                      input int fr, input int slope, output bit sat);
    longint thr, s, y, mx, mn;
    sat = 1'b0;
    thr = longint'(3) << fr;
    mx  = (longint'(1) << (wd - 1)) - 1;
    mn  = -mx - 1;
    case (mode)
      0: return x;
      1: return (x > 0) ? x : 0;
      3: return (x >= 0) ? x : (x >>> 3);
      default: begin
        if (x < -thr) return 0;
        if (x > thr) return x;
        s = (longint'(1) << (fr - 1)) + ((longint'(slope) * x) >>> fr);
        y = (x * s) >>> fr;
        if (y > mx) begin sat = 1'b1; return mx; end
        if (y < mn) begin sat = 1'b1; return mn; end
        return y;
      end
    endcase
  endfunction

  function automatic logic [63:0] ref_vec(input logic [1:0] m, input logic [63:0] d,
                                          output int nsat);
    logic [63:0] r;
    logic [15:0] lane;
    longint      v;
    bit          s;
    nsat = 0;
    r = '0;
    for (int i = 0; i < L; i++) begin
      lane = d[i*W +: W];
      v = ref_lane(int'(m), longint'($signed(lane)), W, F, SL, s);
      r[i*W +: W] = v[15:0];
      nsat += int'(s);
    end
    return r;
  endfunction

  task automatic send_and_check(input string nm, input logic [1:0] m,
                                input logic [63:0] d, input logic [63:0] e);
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
    tick;
    in_valid = 1'b0; in_data = '0;
    tick;
    check({nm, "_early"}, out_valid, 1'b0);
    tick;
    check({nm, "_valid"}, out_valid, 1'b1);
    check({nm, "_data"}, out_data, e);
  endtask

  task automatic send8(input string nm, input logic [1:0] m, input logic [127:0] d,
                       input logic [127:0] e, input logic [15:0] sc);
    b_in_valid = 1'b1; b_in_mode = m; b_in_data = d; b_out_ready = 1'b1;
    tick;
    b_in_valid = 1'b0;
    tick;
    tick;
    check({nm, "_valid"}, b_out_valid, 1'b1);
    check({nm, "_data"}, b_out_data, e);
    check({nm, "_sat"}, b_sat_count, sc);
  endtask

  task automatic gen(input bit rnd, input int k, output logic [1:0] m, output logic [63:0] d);
    logic [15:0] v;
    if (rnd) begin
      m = 2'($urandom_range(3));
      for (int i = 0; i < L; i++) begin
        if ($urandom_range(1) == 1) v = 16'($urandom);
        else v = 16'($urandom_range(2048) - 1024);
        d[i*W +: W] = v;
      end
    end else begin
      m = 2'(k % 4);
      d = p4(k * 37 - 100, -(k * 50), k * 1000, 7 - k);
    end
  endtask

  task automatic stream(input int n, input bit rnd, input int st_lo, input int st_hi);
    logic [63:0] expq [$];
    logic [63:0] prev, d, e;
    logic [1:0]  m;
    bit          prev_hold;
    int          sent, got, cyc, ns, exp_sat;
    sent = 0; got = 0; cyc = 0; exp_sat = 0; prev_hold = 1'b0; prev = '0;
    gen(rnd, 0, m, d);
    while (got < n && cyc < 20 * n + 100) begin
      in_valid  = (sent < n) && (!rnd || $urandom_range(3) != 0);
      out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= st_lo && cyc <= st_hi);
      in_mode   = m;
      in_data   = d;
      #3;
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev);
      end
      if (!rnd && cyc >= st_lo && cyc <= st_hi) check("stall_in_ready", in_ready, 1'b0);
      if (in_valid && in_ready) begin
        e = ref_vec(m, d, ns);
        expq.push_back(e);
        exp_sat += ns;
        sent++;
        gen(rnd, sent, m, d);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("stream_extra", 1'b1, 1'b0);
        else check("stream_data", out_data, expq.pop_front());
        got++;
      end
      prev_hold = out_valid && !out_ready;
      prev      = out_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 128'(got), 128'(n));
    repeat (4) tick;
    check("stream_drained", out_valid, 1'b0);
    check("stream_sat", sat_count, (exp_sat > 65535) ? 16'hFFFF : 16'(exp_sat));
  endtask

  initial begin
    logic [127:0] d8, e8;

    tbl[0] = '{2'd2, p4(256, -256, 768, -800), p4(171, -85, 771, 0)};
    tbl[1] = '{2'd0, p4(1, -1, 32767, -32768), p4(1, -1, 32767, -32768)};
    tbl[2] = '{2'd1, p4(5, -64, 0, -32768), p4(5, 0, 0, 0)};
    tbl[3] = '{2'd3, p4(-64, -1, 100, -32768), p4(-8, -1, 100, -4096)};
    tbl[4] = '{2'd2, p4(769, -769, 0, -1), p4(769, 0, 0, -1)};
    tbl[5] = '{2'd2, p4(-768, 128, -128, 512), p4(3, 74, -53, 428)};

    rst = 1'b1;
    in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_mode = '0; b_in_data = '0; b_out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_sat", sat_count, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick;

    foreach (tbl[k]) send_and_check($sformatf("vec%0d", k), tbl[k].mode, tbl[k].data, tbl[k].exp);
    check("vec_sat", sat_count, '0);

    // Back-to-back mode 1 then mode 3 on the same value.
    in_valid = 1'b1; in_mode = 2'd1; in_data = p4(-64, 0, 0, 0);
    tick;
    in_mode = 2'd3;
    tick;
    in_valid = 1'b0;
    check("b2b_gap", out_valid, 1'b0);
    tick;
    check("b2b_m1_valid", out_valid, 1'b1);
    check("b2b_m1_data", out_data, p4(0, 0, 0, 0));
    tick;
    check("b2b_m3_valid", out_valid, 1'b1);
    check("b2b_m3_data", out_data, p4(-8, 0, 0, 0));
    tick;
    check("b2b_end", out_valid, 1'b0);

    stream(10, 1'b0, 4, 7);

    // Clamp path on the narrow instance.
    d8 = '0; d8[7:0] = 8'd47; d8[15:8] = 8'hD0; d8[23:16] = 8'd49; d8[31:24] = 8'hCF;
    e8 = '0; e8[7:0] = 8'h7F; e8[15:8] = 8'h7F; e8[23:16] = 8'd49;
    send8("n8_gelu", 2'd2, d8, e8, 16'd2);
    send8("n8_pass", 2'd0, d8, d8, 16'd2);

    b_in_valid = 1'b1; b_in_mode = 2'd2; b_in_data = {16{8'd47}};
    repeat (100) tick;
    check("n8_burst_valid", b_out_valid, 1'b1);
    check("n8_burst_data", b_out_data, {16{8'h7F}});
    check("n8_burst_sat", b_sat_count, 16'd1570);
    repeat (3997) tick;
    check("n8_near_max", b_sat_count, 16'd65522);
    tick;
    check("n8_sat_max", b_sat_count, 16'hFFFF);
    repeat (5) tick;
    check("n8_no_wrap", b_sat_count, 16'hFFFF);
    b_in_valid = 1'b0;
    repeat (3) tick;

    // Reset with three vectors in flight.
    in_valid = 1'b1; in_mode = 2'd0; in_data = p4(11, 22, 33, 44); out_ready = 1'b1;
    repeat (3) tick;
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_sat", sat_count, '0);
    check("mid_rst_sat8", b_sat_count, '0);
    in_valid = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      check("post_rst_idle", out_valid, 1'b0);
    end
    send_and_check("post_rst", 2'd3, p4(-800, 800, -9, 9), p4(-100, 800, -2, 9));
    tick;

    stream(10000, 1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
